// File: rtl/synth_core.sv
// Five-channel tone synthesizer. Every channel advances once per synchronized 48 kHz tick.
// The stereo mix is registered on that same tick.
module synth_core #(
    parameter int NCH     = 5,
    parameter int NREGS   = 36,
    parameter int ENV_DIV = 64
) (
    input  logic               clk_50mhz,
    input  logic               reset_n,
    input  logic               clk_48khz,
    input  logic [7:0]         regs [0:NREGS-1],
    output logic signed [15:0] audio_out_left,
    output logic signed [15:0] audio_out_right,
    output logic               dummys [0:NCH-1]
);

    logic sync_a, sync_b, sync_prev;
    logic tick;

    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            sync_a    <= 1'b0;
            sync_b    <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync_a    <= clk_48khz;
            sync_b    <= sync_a;
            sync_prev <= sync_b;
        end
    end

    assign tick = sync_b & ~sync_prev;

    logic signed [15:0] left_part  [NCH];
    logic signed [15:0] right_part [NCH];

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        localparam int B = (k == 0) ? 0 : (k == 1) ? 9 : (k == 2) ? 18 : (k == 3) ? 24 : 30;

        logic [7:0]  ctrl, duty, pan, rate;
        logic [15:0] inc;
        logic        enable, trig;
        logic [3:0]  vol;
        logic [1:0]  wave;

        logic        tog;
        logic [15:0] phase, env_cnt;
        logic [3:0]  env;
        logic [14:0] lfsr;

        logic [15:0]        freq_new, env_cnt_new, phase_eff, env_period;
        logic [3:0]         env_new;
        logic [14:0]        lfsr_eff, lfsr_new;
        logic [16:0]        phase_sum;
        logic [7:0]         p;
        logic [6:0]         tri_t;
        logic signed [7:0]  w;
        logic signed [11:0] v;

        assign ctrl       = regs[B];
        assign inc        = {regs[B+2], regs[B+1]};
        assign duty       = regs[B+3];
        assign pan        = regs[B+4];
        assign rate       = regs[B+5];
        assign enable     = ctrl[7];
        assign wave       = ctrl[5:4];
        assign vol        = ctrl[3:0];
        assign trig       = ctrl[6] ^ tog;
        assign env_period = 16'(rate) * 16'(ENV_DIV);

        if (k < 2) begin : g_sweep
            logic [15:0] freq, sweep_cnt, sweep_cnt_new, sweep_period;
            logic [17:0] freq_sum;

            assign sweep_period = 16'(regs[B+6]) * 16'(ENV_DIV);
            assign freq_sum     = {2'b00, freq} + {{10{regs[B+7][7]}}, regs[B+7]};

            always_comb begin
                freq_new      = freq;
                sweep_cnt_new = sweep_cnt;
                if (trig || regs[B+6] == 8'd0) begin
                    freq_new      = inc;
                    sweep_cnt_new = '0;
                end else if (sweep_cnt + 16'd1 >= sweep_period) begin
                    sweep_cnt_new = '0;
                    if (freq_sum[17])
                        freq_new = '0;
                    else if (freq_sum[16])
                        freq_new = 16'hFFFF;
                    else
                        freq_new = freq_sum[15:0];
                end else begin
                    sweep_cnt_new = sweep_cnt + 16'd1;
                end
            end

            always_ff @(posedge clk_50mhz or negedge reset_n) begin
                if (!reset_n) begin
                    freq      <= '0;
                    sweep_cnt <= '0;
                end else if (tick) begin
                    freq      <= freq_new;
                    sweep_cnt <= sweep_cnt_new;
                end
            end
        end else begin : g_fixed
            assign freq_new = inc;
        end

        // The envelope value used in a tick's sample already includes that tick's decay step.
        always_comb begin
            env_new     = env;
            env_cnt_new = env_cnt;
            if (trig || rate == 8'd0) begin
                env_new     = vol;
                env_cnt_new = '0;
            end else if (env_cnt + 16'd1 >= env_period) begin
                env_new     = (env == 4'd0) ? 4'd0 : env - 4'd1;
                env_cnt_new = '0;
            end else begin
                env_cnt_new = env_cnt + 16'd1;
            end
        end

        always_comb begin
            phase_eff = (trig || !enable) ? 16'd0 : phase;
            lfsr_eff  = trig ? 15'h7FFF : lfsr;
            phase_sum = enable ? ({1'b0, phase_eff} + {1'b0, freq_new}) : 17'd0;
            lfsr_new  = phase_sum[16] ? {lfsr_eff[13:0], lfsr_eff[14] ^ lfsr_eff[13]} : lfsr_eff;
            p         = phase_eff[15:8];
            tri_t     = p[7] ? ~p[6:0] : p[6:0];
            w         = '0;
            // 2t-127 equals {t,1} with its MSB flipped, which keeps the triangle in 8 bits.
            unique case (wave)
                2'd0:    w = (p < duty) ? 8'sd127 : -8'sd127;
                2'd1:    w = (p == 8'h00) ? -8'sd127 : $signed({~p[7], p[6:0]});
                2'd2:    w = $signed({~tri_t[6], tri_t[5:0], 1'b1});
                default: w = lfsr_eff[0] ? 8'sd127 : -8'sd127;
            endcase
            v = enable ? ($signed({{4{w[7]}}, w}) * $signed({8'b0, env_new})) : 12'sd0;
        end

        assign left_part[k]  = $signed({{4{v[11]}}, v}) * $signed({12'b0, pan[7:4]});
        assign right_part[k] = $signed({{4{v[11]}}, v}) * $signed({12'b0, pan[3:0]});

        always_ff @(posedge clk_50mhz or negedge reset_n) begin
            if (!reset_n) begin
                tog     <= 1'b0;
                phase   <= '0;
                env     <= '0;
                env_cnt <= '0;
                lfsr    <= 15'h7FFF;
            end else if (tick) begin
                tog     <= ctrl[6];
                phase   <= phase_sum[15:0];
                env     <= env_new;
                env_cnt <= env_cnt_new;
                lfsr    <= lfsr_new;
            end
        end

        assign dummys[k] = tog;
    end

    logic unused_reserved;
    assign unused_reserved = ^{regs[8], regs[17]};

    function automatic logic signed [15:0] sat16(input logic signed [18:0] s);
        logic signed [18:0] h;
        h = s >>> 1;
        if (h > 19'sd32767)
            return 16'sd32767;
        else if (h < -19'sd32768)
            return -16'sd32768;
        return h[15:0];
    endfunction

    logic signed [18:0] sum_l, sum_r;

    always_comb begin
        sum_l = '0;
        sum_r = '0;
        for (int k = 0; k < NCH; k++) begin
            sum_l = sum_l + {{3{left_part[k][15]}}, left_part[k]};
            sum_r = sum_r + {{3{right_part[k][15]}}, right_part[k]};
        end
    end

    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            audio_out_left  <= '0;
            audio_out_right <= '0;
        end else if (tick) begin
            audio_out_left  <= sat16(sum_l);
            audio_out_right <= sat16(sum_r);
        end
    end

endmodule

// File: tb/tb_synth_core.sv
// Bench for synth_core: directed and random register settings scored against a tick-level model.
`timescale 1ns/1ps
module tb_synth_core;

    logic               clk_50mhz = 1'b0;
    logic               reset_n   = 1'b0;
    logic               clk_48khz = 1'b0;
    logic [7:0]         regs [0:35];
    logic signed [15:0] audio_out_left, audio_out_right;
    logic               dummys [0:4];

    synth_core dut (
        .clk_50mhz      (clk_50mhz),
        .reset_n        (reset_n),
        .clk_48khz      (clk_48khz),
        .regs           (regs),
        .audio_out_left (audio_out_left),
        .audio_out_right(audio_out_right),
        .dummys         (dummys)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    typedef struct {
        int         left;
        int         right;
        logic [4:0] ack;
    } sample_t;

    sample_t expect_q [$];
    int checks = 0;
    int errors = 0;
    int ticks_checked = 0;

    int base_of [5] = '{0, 9, 18, 24, 30};
    int m_phase [5], m_env [5], m_freq [5], m_lfsr [5], m_env_age [5], m_sweep_age [5];
    bit m_tog [5];

    task automatic compare(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("[TB] FAIL %s at sample %0d: got %0d, expected %0d", name, ticks_checked, got, want);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 5; k++) begin
            m_phase[k] = 0; m_env[k] = 0; m_freq[k] = 0; m_lfsr[k] = 32'h7FFF;
            m_env_age[k] = 0; m_sweep_age[k] = 0; m_tog[k] = 1'b0;
        end
    endtask

    function automatic int clampRange(input int x, input int lo, input int hi);
        return (x < lo) ? lo : (x > hi) ? hi : x;
    endfunction

    // One sample period of the reference: apply trigger/envelope/sweep rules, emit the sample, then advance phase.
    task automatic modelTick(output sample_t s);
        int sum_l, sum_r;
        sum_l = 0;
        sum_r = 0;
        for (int k = 0; k < 5; k++) begin
            int b, vol, wave, inc, rate, speriod, p, t, w, v, fb;
            logic [7:0] c;
            b = base_of[k];
            c = regs[b];
            vol = int'(c[3:0]);
            wave = int'(c[5:4]);
            inc = int'({regs[b+2], regs[b+1]});
            rate = int'(regs[b+5]);
            speriod = (k < 2) ? int'(regs[b+6]) : 0;
            if (c[6] != m_tog[k]) begin
                m_tog[k] = c[6]; m_phase[k] = 0; m_env[k] = vol; m_freq[k] = inc;
                m_env_age[k] = 0; m_sweep_age[k] = 0; m_lfsr[k] = 32'h7FFF;
            end else begin
                if (rate == 0) begin
                    m_env[k] = vol; m_env_age[k] = 0;
                end else begin
                    m_env_age[k]++;
                    if (m_env_age[k] >= rate * 64) begin
                        m_env_age[k] = 0;
                        if (m_env[k] > 0) m_env[k]--;
                    end
                end
                if (speriod == 0) begin
                    m_freq[k] = inc; m_sweep_age[k] = 0;
                end else begin
                    m_sweep_age[k]++;
                    if (m_sweep_age[k] >= speriod * 64) begin
                        m_sweep_age[k] = 0;
                        m_freq[k] = clampRange(m_freq[k] + int'($signed(regs[b+7])), 0, 65535);
                    end
                end
            end
            if (!c[7]) m_phase[k] = 0;
            p = m_phase[k] / 256;
            case (wave)
                0: w = (p < int'(regs[b+3])) ? 127 : -127;
                1: w = (p == 0) ? -127 : p - 128;
                2: begin t = (p >= 128) ? 255 - p : p; w = 2 * t - 127; end
                default: w = ((m_lfsr[k] & 1) != 0) ? 127 : -127;
            endcase
            v = c[7] ? w * m_env[k] : 0;
            sum_l += v * int'(regs[b+4][7:4]);
            sum_r += v * int'(regs[b+4][3:0]);
            if (c[7]) begin
                m_phase[k] += m_freq[k];
                if (m_phase[k] >= 65536) begin
                    m_phase[k] -= 65536;
                    fb = ((m_lfsr[k] >> 14) ^ (m_lfsr[k] >> 13)) & 1;
                    m_lfsr[k] = ((m_lfsr[k] << 1) | fb) & 32'h7FFF;
                end
            end
            s.ack[k] = m_tog[k];
        end
        s.left  = clampRange(sum_l >>> 1, -32768, 32767);
        s.right = clampRange(sum_r >>> 1, -32768, 32767);
    endtask

    task automatic applyStimulus(input int n);
        sample_t s;
        @(negedge clk_50mhz);
        for (int i = 0; i < n; i++) begin
            modelTick(s);
            expect_q.push_back(s);
            clk_48khz = 1'b1;
            repeat (8) @(negedge clk_50mhz);
            clk_48khz = 1'b0;
            repeat (8) @(negedge clk_50mhz);
        end
    endtask

    task automatic checkOutput();
        sample_t e;
        logic [4:0] got_ack;
        for (int k = 0; k < 5; k++) got_ack[k] = dummys[k];
        if (expect_q.size() == 0) begin
            compare("scoreboard_depth", 0, 1);
            return;
        end
        e = expect_q.pop_front();
        compare("left", int'(audio_out_left), e.left);
        compare("right", int'(audio_out_right), e.right);
        compare("ack", int'(got_ack), int'(e.ack));
        ticks_checked++;
    endtask

    task automatic checkResetState();
        logic [4:0] got_ack;
        for (int k = 0; k < 5; k++) got_ack[k] = dummys[k];
        compare("reset_left", int'(audio_out_left), 0);
        compare("reset_right", int'(audio_out_right), 0);
        compare("reset_ack", int'(got_ack), 0);
    endtask

    function automatic logic [7:0] flipped(input int k, input logic [7:0] c);
        logic [7:0] r;
        r = c;
        r[6] = ~m_tog[k];
        return r;
    endfunction

    function automatic logic [7:0] held(input int k, input logic [7:0] c);
        logic [7:0] r;
        r = c;
        r[6] = m_tog[k];
        return r;
    endfunction

    task automatic setChannel(input int k, input logic [7:0] c, input logic [15:0] inc,
                              input logic [7:0] duty, input logic [7:0] pan, input logic [7:0] rate);
        regs[base_of[k]]   = c;
        regs[base_of[k]+1] = inc[7:0];
        regs[base_of[k]+2] = inc[15:8];
        regs[base_of[k]+3] = duty;
        regs[base_of[k]+4] = pan;
        regs[base_of[k]+5] = rate;
    endtask

    initial begin
        forever begin
            @(posedge clk_48khz);
            repeat (12) @(negedge clk_50mhz);
            checkOutput();
        end
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time exceeded, got %0d samples checked", ticks_checked);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 36; i++) regs[i] = 8'h00;
        modelReset();
        repeat (5) @(negedge clk_50mhz);
        checkResetState();
        reset_n = 1'b1;
        applyStimulus(8);

        $display("[TB] ch0 square");
        setChannel(0, 8'h8F, 16'h0100, 8'h80, 8'hF0, 8'h00);
        applyStimulus(300);

        $display("[TB] ch0 retrigger");
        regs[0] = flipped(0, 8'h8F);
        applyStimulus(10);

        $display("[TB] all channels saturate");
        for (int k = 0; k < 5; k++) setChannel(k, flipped(k, 8'h8F), 16'h0100, 8'hFF, 8'hFF, 8'h00);
        applyStimulus(20);

        $display("[TB] ch2 envelope decay");
        for (int k = 0; k < 5; k++) regs[base_of[k]] = held(k, 8'h00);
        setChannel(2, flipped(2, 8'h8F), 16'h0100, 8'h80, 8'hFF, 8'h01);
        applyStimulus(1000);

        $display("[TB] ch0 sweep");
        regs[base_of[2]] = held(2, 8'h00);
        setChannel(0, flipped(0, 8'h9F), 16'h0100, 8'h80, 8'hF0, 8'h00);
        regs[6] = 8'h01;
        regs[7] = 8'h10;
        applyStimulus(400);

        $display("[TB] ch0 sweep saturation");
        setChannel(0, flipped(0, 8'h9F), 16'hFFF8, 8'h80, 8'hF0, 8'h00);
        applyStimulus(300);

        $display("[TB] random settings");
        for (int seg = 0; seg < 4; seg++) begin
            for (int i = 0; i < 36; i++) regs[i] = 8'($urandom);
            for (int k = 0; k < 5; k++) regs[base_of[k]+5] = 8'($urandom_range(0, 2));
            regs[6]  = 8'($urandom_range(0, 2));
            regs[15] = 8'($urandom_range(0, 2));
            applyStimulus(150);
            if (seg == 1) begin
                reset_n = 1'b0;
                #3;
                checkResetState();
                modelReset();
                repeat (2) @(negedge clk_50mhz);
                reset_n = 1'b1;
            end
        end

        repeat (20) @(negedge clk_50mhz);
        compare("scoreboard_leftover", expect_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
